// File: rtl/mem_stage_mw.sv
// mem_stage_mw: Y86-64 memory stage between the M and W pipeline registers.
// Owns a big-endian byte-addressed data memory with synchronous writes,
// full-word bounds checking and optional wait states with a stall handshake.
// Optional build macro: DMEM_ALIGN_CHECK_EN (unaligned accesses raise ADR).
module mem_stage_mw #(
    parameter int MEM_BYTES   = 1024,
    parameter int ADDR_W      = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              M_valid,
    input  logic [3:0]        M_stat,
    input  logic [3:0]        M_icode,
    input  logic              M_Cnd,
    input  logic [ADDR_W-1:0] M_valE,
    input  logic [ADDR_W-1:0] M_valA,
    input  logic [3:0]        M_dstE,
    input  logic [3:0]        M_dstM,
    output logic [3:0]        m_stat,
    output logic [3:0]        m_icode,
    output logic [ADDR_W-1:0] m_valE,
    output logic [3:0]        m_dstE,
    output logic [3:0]        m_dstM,
    output logic [63:0]       m_valM,
    output logic              m_stall,
    output logic [15:0]       m_wr_cnt
);

    localparam int              IDX_W   = $clog2(MEM_BYTES);
    localparam logic [3:0]      WS      = 4'(WAIT_STATES);
    localparam logic [ADDR_W:0] LAST_OK = (ADDR_W+1)'(MEM_BYTES - 8);

    typedef enum logic {S_IDLE, S_WAIT} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [15:0]       wr_cnt_q, wr_cnt_d;
    logic [7:0]        mem_q [MEM_BYTES];

    logic              is_rd, is_wr, use_e;
    logic [ADDR_W-1:0] addr;
    logic [IDX_W-1:0]  base;
    logic              acc, adr_err, acc_ok;
    logic              stall, complete, do_write;
    logic [63:0]       st_data, rd_word;

    // Condition flag is carried by the pipeline register, not used here
    logic              unused_cnd;
    assign unused_cnd = M_Cnd;

    // Instruction decode and effective address selection
    always_comb begin
        is_rd = (M_icode == 4'h5) || (M_icode == 4'h9) || (M_icode == 4'hB);
        is_wr = (M_icode == 4'h4) || (M_icode == 4'h8) || (M_icode == 4'hA);
        use_e = (M_icode == 4'h4) || (M_icode == 4'h5) ||
                (M_icode == 4'h8) || (M_icode == 4'hA);
        addr  = use_e ? M_valE : M_valA;
        base  = addr[IDX_W-1:0];
    end

    assign acc = M_valid & (is_rd | is_wr) & M_stat[3];

`ifdef DMEM_ALIGN_CHECK_EN
    assign adr_err = acc & (({1'b0, addr} > LAST_OK) | (addr[2:0] != 3'b000));
`else
    assign adr_err = acc & ({1'b0, addr} > LAST_OK);
`endif

    assign acc_ok = acc & ~adr_err;

    // Wait-state sequencing: decides stall, completion and next state
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall    = 1'b0;
        complete = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (acc_ok) begin
                    if (WS != 4'd0) begin
                        stall   = 1'b1;
                        cnt_d   = 4'd1;
                        state_d = S_WAIT;
                    end else begin
                        complete = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                // Losing the access mid-wait abandons it without a write
                if (!acc_ok) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != WS) begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    complete = 1'b1;
                    state_d  = S_IDLE;
                    cnt_d    = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign do_write = complete & is_wr;
    assign wr_cnt_d = wr_cnt_q + {15'd0, do_write};
    assign st_data  = 64'(M_valA);

    // Sequencer state and committed-write counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            wr_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    // Big-endian word store; memory contents survive reset
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int unsigned k = 0; k < 8; k++) begin
                mem_q[base + IDX_W'(k)] <= st_data[8*(7-k) +: 8];
            end
        end
    end

    // Big-endian combinational word read
    always_comb begin
        rd_word = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            rd_word = {rd_word[55:0], mem_q[base + IDX_W'(k)]};
        end
    end

    // Status update and pass-through outputs
    always_comb begin
        if (!M_valid) begin
            m_stat = M_stat;
        end else begin
            m_stat = {M_stat[3] & ~adr_err, M_stat[2], M_stat[1] | adr_err, M_stat[0]};
        end
    end

    assign m_icode  = M_icode;
    assign m_valE   = M_valE;
    assign m_dstE   = M_dstE;
    assign m_dstM   = M_dstM;
    assign m_valM   = (complete & is_rd) ? rd_word : '0;
    assign m_stall  = stall & rst_n;
    assign m_wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_mem_stage_mw.sv
// Bench for mem_stage_mw: one single-cycle and one wait-state instance,
// each compared against a byte-array reference model.
module tb_mem_stage_mw;

    localparam int         MEM = 1024;
    localparam logic [3:0] AOK = 4'b1000;
    localparam logic [3:0] INS = 4'b0100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [2];
    logic        v   [2];
    logic [3:0]  st  [2];
    logic [3:0]  ic  [2];
    logic        cnd [2];
    logic [63:0] ve  [2];
    logic [63:0] va  [2];
    logic [3:0]  de  [2];
    logic [3:0]  dm  [2];

    logic [3:0]  o_stat  [2];
    logic [3:0]  o_icode [2];
    logic [63:0] o_valE  [2];
    logic [3:0]  o_dstE  [2];
    logic [3:0]  o_dstM  [2];
    logic [63:0] o_valM  [2];
    logic        o_stall [2];
    logic [15:0] o_wrcnt [2];

    mem_stage_mw #(.MEM_BYTES(MEM), .ADDR_W(64), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst_n(rst[0]), .M_valid(v[0]), .M_stat(st[0]), .M_icode(ic[0]),
        .M_Cnd(cnd[0]), .M_valE(ve[0]), .M_valA(va[0]), .M_dstE(de[0]), .M_dstM(dm[0]),
        .m_stat(o_stat[0]), .m_icode(o_icode[0]), .m_valE(o_valE[0]), .m_dstE(o_dstE[0]),
        .m_dstM(o_dstM[0]), .m_valM(o_valM[0]), .m_stall(o_stall[0]), .m_wr_cnt(o_wrcnt[0])
    );

    mem_stage_mw #(.MEM_BYTES(MEM), .ADDR_W(64), .WAIT_STATES(3)) u_dut3 (
        .clk(clk), .rst_n(rst[1]), .M_valid(v[1]), .M_stat(st[1]), .M_icode(ic[1]),
        .M_Cnd(cnd[1]), .M_valE(ve[1]), .M_valA(va[1]), .M_dstE(de[1]), .M_dstM(dm[1]),
        .m_stat(o_stat[1]), .m_icode(o_icode[1]), .m_valE(o_valE[1]), .m_dstE(o_dstE[1]),
        .m_dstM(o_dstM[1]), .m_valM(o_valM[1]), .m_stall(o_stall[1]), .m_wr_cnt(o_wrcnt[1])
    );

    // Reference model state
    logic [7:0]  mm [2][MEM];
    logic [15:0] cnt_m [2];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int ws(input int sel);
        return (sel == 0) ? 0 : 3;
    endfunction

    function automatic logic [63:0] mread(input int sel, input logic [63:0] a);
        logic [63:0] r = '0;
        for (int k = 0; k < 8; k++) r = {r[55:0], mm[sel][int'(a) + k]};
        return r;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [63:0] rnd_addr();
        int r = $urandom_range(0, 99);
        if (r < 80) return 64'($urandom_range(0, MEM - 8));
        if (r < 92) return 64'($urandom_range(MEM - 7, MEM + 8));
        return rnd64();
    endfunction

    // Present one instruction, follow it through every cycle it occupies,
    // then retire it into the model. Called and returns at posedge+1.
    task automatic issue(input int sel, input bit vld, input logic [3:0] stt,
                         input logic [3:0] icd, input logic [63:0] e, input logic [63:0] a);
        bit          rd, wr, acc, err, ok;
        logic [63:0] addr, word;
        logic [3:0]  xstat;
        int          ncyc;
        rd   = (icd == 4'h5) || (icd == 4'h9) || (icd == 4'hB);
        wr   = (icd == 4'h4) || (icd == 4'h8) || (icd == 4'hA);
        addr = ((icd == 4'h4) || (icd == 4'h5) || (icd == 4'h8) || (icd == 4'hA)) ? e : a;
        acc  = vld && (rd || wr) && stt[3];
        err  = acc && (addr > 64'(MEM - 8));
`ifdef DMEM_ALIGN_CHECK_EN
        if (acc && addr[2:0] != 3'b000) err = 1'b1;
`endif
        ok    = acc && !err;
        xstat = vld ? {stt[3] & ~err, stt[2], stt[1] | err, stt[0]} : stt;
        ncyc  = ok ? ws(sel) + 1 : 1;
        word  = (ok && rd) ? mread(sel, addr) : 64'd0;

        v[sel] = vld; st[sel] = stt; ic[sel] = icd; ve[sel] = e; va[sel] = a;
        cnd[sel] = 1'($urandom); de[sel] = 4'($urandom); dm[sel] = 4'($urandom);

        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            check("stall", 64'(o_stall[sel]), 64'(ok && c < ws(sel)));
            check("valM", o_valM[sel], (c == ncyc - 1) ? word : 64'd0);
            if (c == 0) begin
                check("stat", 64'(o_stat[sel]), 64'(xstat));
                check("pass", {o_icode[sel], o_dstE[sel], o_dstM[sel], o_valE[sel][51:0]},
                              {icd, de[sel], dm[sel], e[51:0]});
            end
            @(posedge clk); #1;
        end
        v[sel] = 1'b0;
        if (ok && wr) begin
            for (int k = 0; k < 8; k++) mm[sel][int'(addr) + k] = a[8*(7-k) +: 8];
            cnt_m[sel] = cnt_m[sel] + 16'd1;
        end
        check("wr_cnt", 64'(o_wrcnt[sel]), 64'(cnt_m[sel]));
    endtask

    task automatic rand_op(input int sel);
        logic [3:0]  icd = 4'($urandom);
        logic [3:0]  stt;
        logic [63:0] a;
        int          r = $urandom_range(0, 7);
        stt = (r < 5) ? AOK : (4'b0001 << $urandom_range(0, 2));
        a   = ((icd == 4'h9) || (icd == 4'hB)) ? rnd_addr() : rnd64();
        issue(sel, ($urandom_range(0, 9) != 0), stt, icd, rnd_addr(), a);
    endtask

    initial begin
        logic [63:0] old;
        for (int s = 0; s < 2; s++) begin
            rst[s] = 1'b0; v[s] = 1'b0; st[s] = AOK; ic[s] = 4'h0; cnd[s] = 1'b0;
            ve[s] = '0; va[s] = '0; de[s] = '0; dm[s] = '0; cnt_m[s] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            check("rst_stall", 64'(o_stall[s]), 64'd0);
            check("rst_wrcnt", 64'(o_wrcnt[s]), 64'd0);
        end
        @(negedge clk);
        rst[0] = 1'b1; rst[1] = 1'b1;
        @(posedge clk); #1;

        // Give both memories known contents
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < MEM / 8; i++) issue(s, 1'b1, AOK, 4'h4, 64'(i * 8), rnd64());

        // Single-cycle store/load, bounds edge, bubble, bad status, unaligned word
        issue(0, 1'b1, AOK, 4'h4, 64'h10, 64'h0123456789ABCDEF);
        issue(0, 1'b1, AOK, 4'h5, 64'h10, 64'h0);
        issue(0, 1'b1, AOK, 4'h5, 64'h3F9, 64'h0);
        issue(0, 1'b1, AOK, 4'h5, 64'h3F8, 64'h0);
        issue(0, 1'b0, AOK, 4'h4, 64'h20, rnd64());
        issue(0, 1'b1, INS, 4'h4, 64'h20, rnd64());
        issue(0, 1'b1, AOK, 4'h4, 64'h13, 64'hA1B2C3D4E5F60718);
        issue(0, 1'b1, AOK, 4'h5, 64'h13, 64'h0);
        issue(0, 1'b1, AOK, 4'h4, 64'hFFFF_FFFF_FFFF_FFF8, rnd64());

        // Wait-state push then pop at the last legal word
        issue(1, 1'b1, AOK, 4'hA, 64'h3F8, 64'hCAFEF00DDEADBEEF);
        issue(1, 1'b1, AOK, 4'hB, 64'h0, 64'h3F8);
        issue(1, 1'b1, AOK, 4'h5, 64'h3F9, 64'h0);

        for (int i = 0; i < 300; i++) begin
            rand_op(0);
            rand_op(1);
        end

        // Reset in the middle of a waiting store
        old = mread(1, 64'h200);
        v[1] = 1'b1; st[1] = AOK; ic[1] = 4'h4; ve[1] = 64'h200; va[1] = ~old;
        @(negedge clk); check("rst_mid_stall0", 64'(o_stall[1]), 64'd1);
        @(posedge clk); #1;
        @(negedge clk); check("rst_mid_stall1", 64'(o_stall[1]), 64'd1);
        rst[1] = 1'b0;
        #1;
        check("rst_mid_drop", 64'(o_stall[1]), 64'd0);
        check("rst_mid_cnt", 64'(o_wrcnt[1]), 64'd0);
        v[1] = 1'b0;
        @(posedge clk); #1;
        rst[1] = 1'b1;
        cnt_m[1] = '0;
        issue(1, 1'b1, AOK, 4'h5, 64'h200, 64'h0);

        // Bubble arriving mid-wait abandons the store
        old = mread(1, 64'h300);
        v[1] = 1'b1; st[1] = AOK; ic[1] = 4'h4; ve[1] = 64'h300; va[1] = ~old;
        @(negedge clk); check("abort_stall0", 64'(o_stall[1]), 64'd1);
        @(posedge clk); #1;
        v[1] = 1'b0;
        @(negedge clk); check("abort_drop", 64'(o_stall[1]), 64'd0);
        @(posedge clk); #1;
        check("abort_cnt", 64'(o_wrcnt[1]), 64'(cnt_m[1]));
        @(negedge clk); check("abort_idle", 64'(o_stall[1]), 64'd0);
        @(posedge clk); #1;
        issue(1, 1'b1, AOK, 4'h5, 64'h300, 64'h0);
        issue(1, 1'b1, AOK, 4'h4, 64'h300, 64'h1122334455667788);
        issue(1, 1'b1, AOK, 4'h5, 64'h300, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_stage_mw.md
Name: mem_stage_mw

Overview:
- Parametrised, clocked successor of the pipelined Y86-64 memory stage.
- Sits between the M and W pipeline registers and owns the data memory array (big-endian 8-byte words).
- Adds over the previous stage: synchronous writes, configurable memory size and address width, configurable wait-state latency with a stall handshake to pipeline control, and full-word bounds checking.

Parameters:
- MEM_BYTES, 1024: data memory size in bytes; must be ≥ 8.
- ADDR_W, 64: width of address-carrying values (valE, valA).
- WAIT_STATES, 0: extra cycles per memory access, range 0..15.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- M_valid  in  1  M register holds a real instruction (0 = bubble)
- M_stat  in  4  one-hot status: [3]AOK [2]INS [1]ADR [0]HLT
- M_icode  in  4  instruction code
- M_Cnd  in  1  condition flag, passed through
- M_valE  in  ADDR_W  ALU result
- M_valA  in  ADDR_W  store data / stack address
- M_dstE  in  4  destination register E
- M_dstM  in  4  destination register M
- m_stat  out  4  updated status
- m_icode, m_valE, m_dstE, m_dstM  out  4/ADDR_W/4/4  combinational pass-through
- m_valM  out  64  load data
- m_stall  out  1  holds the M register and everything upstream
- m_wr_cnt  out  16  committed-write counter, wraps at 16'hFFFF→0

Behaviour:
- Decode:
  - read = icode ∈ {5, 9, B}; write = icode ∈ {4, 8, A}.
  - addr = M_valE for icode ∈ {4, 5, 8, A}; otherwise M_valA.
- Access conditions:
  - acc = M_valid & (read | write) & M_stat[3].
  - adr_err = acc & (addr > MEM_BYTES-8). The compare is done at ADDR_W+1 bits so there is no wrap, and any byte beyond the end is an error.
- Status:
  - m_stat[1] = M_stat[1] | adr_err.
  - m_stat[3] = M_stat[3] & ~adr_err.
  - m_stat[2] and m_stat[0] pass through.
  - When M_valid=0, m_stat = M_stat unchanged.
- Byte order: byte addr+0 = bits [63:56] … addr+7 = bits [7:0], for both load and store.
- FSM: states IDLE and WAIT, with a 4-bit counter cnt.
  - IDLE:
    - If acc & ~adr_err & WAIT_STATES>0: m_stall=1, cnt←1, go to WAIT.
    - Otherwise m_stall=0 and this is the completion cycle.
  - WAIT:
    - If cnt < WAIT_STATES: m_stall=1, cnt←cnt+1.
    - If cnt == WAIT_STATES: m_stall=0, this is the completion cycle, next state IDLE, cnt←0.
- Latency:
  - An access spans WAIT_STATES+1 cycles; m_stall is high for the first WAIT_STATES of them.
  - With WAIT_STATES=0 the stage is single-cycle and never stalls.
- Completion cycle:
  - read: m_valM = memory word at addr (combinational read); otherwise m_valM = 0.
  - write: all 8 bytes are committed at the rising edge ending the cycle and m_wr_cnt increments.
  - A load in the cycle after a store to the same address returns the new data.
- Non-completion cycles: m_valM = 0 and no memory update.
- Error or bubble: no stall, no write, m_valM = 0.
- Hold rule: upstream keeps the M inputs stable while m_stall=1.
  - If M_valid falls or M_stat[3] drops while in WAIT: abort to IDLE, cnt←0, no write.
- Reset:
  - rst_n low: state IDLE, cnt 0, m_wr_cnt 0, m_stall 0 immediately (asynchronous).
  - An in-flight write is discarded.
  - Memory contents are not cleared.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined: acc with addr[2:0] ≠ 0 also raises adr_err (ADR status, no stall, no write, m_valM = 0).
- Undefined: unaligned addresses are legal; only the bounds check applies.

Test Plan:
- WAIT_STATES=0: rmmovq (icode 4) valE=0x10, valA=0x0123456789ABCDEF, then mrmovq (icode 5) valE=0x10 -> m_stall never high; m_valM=0x0123456789ABCDEF; mem[0x10]=0x01, mem[0x17]=0xEF; m_wr_cnt=1.
- WAIT_STATES=3: pushq (icode A) valE=0x3F8 -> m_stall high exactly 3 cycles then low; write lands on the 4th edge; a following popq (icode B) valA=0x3F8 reads back the pushed value after another 3-cycle stall.
- Bounds: mrmovq valE=0x3F9 (MEM_BYTES=1024) -> m_stat=4'b0010, m_valM=0, no stall; valE=0x3F8 -> AOK.
- Bubble and errors: M_valid=0 with icode 4, or M_stat=INS with icode 4 -> no write; m_wr_cnt unchanged; m_stat equals M_stat.
- Reset and abort: WAIT_STATES=5, assert rst_n low mid-WAIT on a store -> m_stall drops immediately; target bytes unchanged; m_wr_cnt=0. Separately, drop M_valid mid-WAIT -> return to IDLE with no write.
- With DMEM_ALIGN_CHECK_EN: rmmovq valE=0x13 -> m_stat[1]=1, no write. Without the macro -> write succeeds at bytes 0x13..0x1A.
